fwd_bypass_buffer: RTL and testbench

Parametrised forwarding network that generalises the fixed 3-way MA/WB operand mux. It keeps a shift buffer of the last DEPTH in-flight register writes (youngest first) and resolves NSRC source operands against it with youngest-wins priority. It also supports late-arriving results (load data filled after allocation) and raises a stall request when the youngest matching producer has no data yet. It sits between the decode/execute pipeline register and the ALU operand inputs and is driven by the hazard unit.

---
 rtl/fwd_bypass_buffer.sv | 128 ++++++++++++
 tb/tb_fwd_bypass_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_bypass_buffer.sv
// Operand forwarding network: tracks the last DEPTH in-flight register writes (slot 0 youngest)
// and resolves NSRC source operands against them, youngest match wins, with late-fill support.
module fwd_bypass_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned REGW  = 5,
    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned SELW = $clog2(DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   hold_i,
    input  logic                   flush_i,
    input  logic                   push_en_i,
    input  logic [REGW-1:0]        push_rd_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   push_rdy_i,
    input  logic                   fill_en_i,
    input  logic [IDXW-1:0]        fill_idx_i,
    input  logic [WIDTH-1:0]       fill_data_i,
    input  logic [NSRC*REGW-1:0]   rs_addr_i,
    input  logic [NSRC*WIDTH-1:0]  rf_data_i,
    output logic [NSRC*WIDTH-1:0]  op_data_o,
    output logic [NSRC*SELW-1:0]   op_sel_o,
    output logic [NSRC-1:0]        op_stall_o,
    output logic                   stall_o
);

    logic [DEPTH-1:0] valid_q, valid_d, valid_f;
    logic [DEPTH-1:0] rdy_q, rdy_d, rdy_f;
    logic [REGW-1:0]  rd_q   [DEPTH];
    logic [REGW-1:0]  rd_d   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] data_f [DEPTH];

    // Fill lands first (the *_f view), then the shift carries the filled entry along.
    always_comb begin
        valid_f = valid_q;
        rdy_f   = rdy_q;
        data_f  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_en_i && valid_q[i] && (fill_idx_i == IDXW'(i))) begin
                data_f[i] = fill_data_i;
                rdy_f[i]  = 1'b1;
            end
        end

        valid_d = valid_f;
        rdy_d   = rdy_f;
        data_d  = data_f;
        rd_d    = rd_q;

        if (flush_i) begin
            valid_d = '0;
            rdy_d   = '0;
        end else if (!hold_i) begin
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_f[i-1];
                rdy_d[i]   = rdy_f[i-1];
                data_d[i]  = data_f[i-1];
                rd_d[i]    = rd_q[i-1];
            end
            valid_d[0] = push_en_i && (push_rd_i != '0);
            rd_d[0]    = push_rd_i;
            data_d[0]  = push_rdy_i ? push_data_i : '0;
            rdy_d[0]   = push_rdy_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            rdy_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    logic [REGW-1:0]  raddr;
    logic             hit;
    logic             hit_rdy;
    logic [WIDTH-1:0] hit_data;
    logic [SELW-1:0]  hit_sel;

    // Scan oldest to youngest so the lowest matching slot is the last assignment and wins.
    always_comb begin
        op_data_o  = '0;
        op_sel_o   = '0;
        op_stall_o = '0;
        raddr      = '0;
        hit        = 1'b0;
        hit_rdy    = 1'b0;
        hit_data   = '0;
        hit_sel    = '0;
        for (int k = 0; k < NSRC; k++) begin
            raddr    = rs_addr_i[k*REGW +: REGW];
            hit      = 1'b0;
            hit_rdy  = 1'b0;
            hit_data = '0;
            hit_sel  = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if ((raddr != '0) && valid_q[i] && (rd_q[i] == raddr)) begin
                    hit      = 1'b1;
                    hit_rdy  = rdy_q[i];
                    hit_data = data_q[i];
                    hit_sel  = SELW'(i + 1);
                end
            end
            op_data_o[k*WIDTH +: WIDTH] = (hit && hit_rdy) ? hit_data : rf_data_i[k*WIDTH +: WIDTH];
            op_sel_o[k*SELW +: SELW]    = hit ? hit_sel : '0;
            op_stall_o[k]               = hit && !hit_rdy;
        end
    end

    assign stall_o = |op_stall_o;

endmodule

// File: tb/tb_fwd_bypass_buffer.sv
// Directed bench for fwd_bypass_buffer (WIDTH=32, DEPTH=3, NSRC=2): stimulus queues expected
// operand views, a negedge monitor pops and compares them.
module tb_fwd_bypass_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned REGW  = 5;
    localparam int unsigned IDXW  = 2;
    localparam int unsigned SELW  = 2;

    logic                  clk = 1'b0;
    logic                  reset, hold, flush, push_en, push_rdy, fill_en;
    logic [REGW-1:0]       push_rd;
    logic [WIDTH-1:0]      push_data, fill_data;
    logic [IDXW-1:0]       fill_idx;
    logic [NSRC*REGW-1:0]  rs_addr;
    logic [NSRC*WIDTH-1:0] rf_data;
    logic [NSRC*WIDTH-1:0] op_data;
    logic [NSRC*SELW-1:0]  op_sel;
    logic [NSRC-1:0]       op_stall;
    logic                  stall;

    fwd_bypass_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .NSRC (NSRC),
        .REGW (REGW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .hold_i      (hold),
        .flush_i     (flush),
        .push_en_i   (push_en),
        .push_rd_i   (push_rd),
        .push_data_i (push_data),
        .push_rdy_i  (push_rdy),
        .fill_en_i   (fill_en),
        .fill_idx_i  (fill_idx),
        .fill_data_i (fill_data),
        .rs_addr_i   (rs_addr),
        .rf_data_i   (rf_data),
        .op_data_o   (op_data),
        .op_sel_o    (op_sel),
        .op_stall_o  (op_stall),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                 name;
        logic [NSRC*WIDTH-1:0] data;
        logic [NSRC*SELW-1:0]  sel;
        logic [NSRC-1:0]       stl;
        logic                  any;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total += 4;
            if (op_data !== e.data) begin
                bad++;
                $display("FAIL %s op_data got=%h want=%h", e.name, op_data, e.data);
            end
            if (op_sel !== e.sel) begin
                bad++;
                $display("FAIL %s op_sel got=%h want=%h", e.name, op_sel, e.sel);
            end
            if (op_stall !== e.stl) begin
                bad++;
                $display("FAIL %s op_stall got=%b want=%b", e.name, op_stall, e.stl);
            end
            if (stall !== e.any) begin
                bad++;
                $display("FAIL %s stall got=%b want=%b", e.name, stall, e.any);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hold      = 1'b0;
        flush     = 1'b0;
        push_en   = 1'b0;
        push_rd   = '0;
        push_data = '0;
        push_rdy  = 1'b0;
        fill_en   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
    endtask

    task automatic push(input logic [REGW-1:0] rd, input logic [WIDTH-1:0] d, input logic rdy);
        push_en   = 1'b1;
        push_rd   = rd;
        push_data = d;
        push_rdy  = rdy;
    endtask

    task automatic fill(input logic [IDXW-1:0] idx, input logic [WIDTH-1:0] d);
        fill_en   = 1'b1;
        fill_idx  = idx;
        fill_data = d;
    endtask

    task automatic set_rs(input logic [REGW-1:0] r1, input logic [REGW-1:0] r0);
        rs_addr = {r1, r0};
    endtask

    task automatic set_rf(input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d0);
        rf_data = {d1, d0};
    endtask

    task automatic expect_op(input string nm, input logic [WIDTH-1:0] d1,
                             input logic [WIDTH-1:0] d0, input logic [SELW-1:0] s1,
                             input logic [SELW-1:0] s0, input logic t1, input logic t0);
        exp_t e;
        e.name = nm;
        e.data = {d1, d0};
        e.sel  = {s1, s0};
        e.stl  = {t1, t0};
        e.any  = t1 | t0;
        exp_q.push_back(e);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        set_rs(0, 0);
        set_rf(0, 0);
        tick();
        tick();
        reset = 1'b0;

        set_rs(2, 1);
        set_rf(32'h22, 32'h11);
        expect_op("reset_view", 32'h22, 32'h11, 0, 0, 0, 0);
        tick();

        idle(); push(5, 32'hAAAA, 1'b1);
        tick();
        idle(); push(5, 32'hBBBB, 1'b1); set_rs(1, 5); set_rf(32'h11, 32'h55);
        expect_op("first_hit", 32'h11, 32'hAAAA, 0, 1, 0, 0);
        tick();
        idle(); expect_op("youngest_wins", 32'h11, 32'hBBBB, 0, 1, 0, 0);
        tick();
        idle(); expect_op("age_slot1", 32'h11, 32'hBBBB, 0, 2, 0, 0);
        tick();
        idle(); expect_op("age_slot2", 32'h11, 32'hBBBB, 0, 3, 0, 0);
        tick();
        idle(); expect_op("aged_out", 32'h11, 32'h55, 0, 0, 0, 0);
        tick();

        idle(); push(7, 32'hDEAD, 1'b0);
        tick();
        // Held cycle: fill applies in place, the push of x9 must be ignored.
        idle(); hold = 1'b1; fill(0, 32'h1234); push(9, 32'h9999, 1'b1);
        set_rs(9, 7); set_rf(32'h99, 32'h77);
        expect_op("stall_hit", 32'h99, 32'h77, 0, 1, 0, 1);
        tick();
        idle(); push(7, 32'h0, 1'b0);
        expect_op("fill_in_place", 32'h99, 32'h1234, 0, 1, 0, 0);
        tick();
        idle(); fill(0, 32'h5678);
        expect_op("stall_shadow", 32'h99, 32'h77, 0, 1, 0, 1);
        tick();
        idle(); fill(2, 32'hEEEE);
        expect_op("fill_shift", 32'h99, 32'h5678, 0, 2, 0, 0);
        tick();
        idle(); hold = 1'b1; fill(3, 32'hBAD0);
        expect_op("fill_last_dropped", 32'h99, 32'h5678, 0, 3, 0, 0);
        tick();
        idle(); hold = 1'b1; fill(0, 32'h0BAD);
        expect_op("fill_oob", 32'h99, 32'h5678, 0, 3, 0, 0);
        tick();
        idle(); push(3, 32'h99, 1'b1);
        expect_op("fill_invalid", 32'h99, 32'h5678, 0, 3, 0, 0);
        tick();

        idle(); flush = 1'b1; push(4, 32'h44, 1'b1); set_rs(4, 3);
        set_rf(32'h4040, 32'h3030);
        expect_op("pre_flush", 32'h4040, 32'h99, 0, 1, 0, 0);
        tick();
        idle(); push(6, 32'h66, 1'b1);
        expect_op("post_flush", 32'h4040, 32'h3030, 0, 0, 0, 0);
        tick();

        idle(); push(0, 32'hFFFF, 1'b1); set_rs(0, 0); set_rf(0, 0);
        expect_op("x0_read", 0, 0, 0, 0, 0, 0);
        tick();
        idle(); expect_op("x0_not_alloc", 0, 0, 0, 0, 0, 0);
        tick();
        idle(); set_rs(6, 6); set_rf(32'h2, 32'h1);
        expect_op("same_reg_both", 32'h66, 32'h66, 3, 3, 0, 0);
        tick();

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
